// File: rtl/ah_snoop_arb_pkg.sv
// Shared types and constants for the snoopable credit FIFO write scheduler.
// Imported by the round-robin arbiter and the scheduler top.
package ah_snoop_arb_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SNOOP_ENC = 2'd1;
    localparam logic [1:0] ST_PUSH_ENC  = 2'd2;
    localparam logic [1:0] ST_DROP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        SNOOP = ST_SNOOP_ENC,
        PUSH  = ST_PUSH_ENC,
        DROP  = ST_DROP_ENC
    } arb_state_e;

    localparam int DROP_CNT_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ah_rr_arbiter.sv
// Round-robin pick: first requester above rr_last, wrapping around.
// Purely combinational; the owner registers rr_last.
module ah_rr_arbiter
    import ah_snoop_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(rr_last) + k) % NUM_REQ;
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ah_snoop_fifo_wr_arb.sv
// Write-side scheduler for a snoopable credit FIFO: round-robin grant,
// credit tracking and optional duplicate drop via a one-cycle snoop.
module ah_snoop_fifo_wr_arb
    import ah_snoop_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 10,
    parameter int DEDUP_EN   = 1,
    localparam int IW = idx_w(NUM_REQ),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [DATA_W-1:0]       fifo_wr_data,
    output logic                    fifo_wr_valid,
    input  logic                    fifo_wr_credit,
    output logic [DATA_W-1:0]       snoop_data,
    output logic                    snoop_valid,
    input  logic                    snoop_match,
    output logic                    drop_pulse,
    output logic [IW-1:0]           drop_id,
    output logic [DROP_CNT_W-1:0]   drop_count,
    output logic                    err_credit_ovf
);

    localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] RR_INIT  = IW'(NUM_REQ - 1);

    arb_state_e          state;
    arb_state_e          state_d;
    logic [DATA_W-1:0]   hold_data;
    logic [IW-1:0]       hold_id;
    logic [IW-1:0]       rr_last;
    logic [CW-1:0]       credit_cnt;
    logic [NUM_REQ-1:0]  gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;
    logic                grant_ok;
    logic                push_now;

    ah_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .rr_last (rr_last),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign grant_ok = (state == IDLE) && gnt_any && (credit_cnt != '0);
    assign push_now = (state == PUSH);

    always_comb begin
        state_d       = state;
        req_ready     = '0;
        fifo_wr_valid = 1'b0;
        fifo_wr_data  = '0;
        snoop_valid   = 1'b0;
        snoop_data    = '0;
        drop_pulse    = 1'b0;
        drop_id       = '0;
        unique case (state)
            IDLE: begin
                if (grant_ok) begin
                    req_ready = gnt;
                    state_d   = (DEDUP_EN != 0) ? SNOOP : PUSH;
                end
            end
            SNOOP: begin
                snoop_valid = 1'b1;
                snoop_data  = hold_data;
                state_d     = snoop_match ? DROP : PUSH;
            end
            PUSH: begin
                fifo_wr_valid = 1'b1;
                fifo_wr_data  = hold_data;
                state_d       = IDLE;
            end
            DROP: begin
                drop_pulse = 1'b1;
                drop_id    = hold_id;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_id   <= '0;
            rr_last   <= RR_INIT;
        end else begin
            state <= state_d;
            if (grant_ok) begin
                hold_data <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
                hold_id   <= gnt_idx;
                rr_last   <= gnt_idx;
            end
        end
    end

    // a push and a return in the same cycle cancel out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit_cnt     <= CRED_MAX;
            err_credit_ovf <= 1'b0;
        end else if (push_now && !fifo_wr_credit) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (!push_now && fifo_wr_credit) begin
            if (credit_cnt == CRED_MAX) begin
                err_credit_ovf <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_count <= '0;
        end else if (state == DROP && drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ah_snoop_fifo_wr_arb.sv
// Scoreboard bench: driver issues requests and credits, a negedge
// monitor predicts grants, snoops, pushes and drops from a queue model.
module tb_ah_snoop_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_wr_data;
    logic        fifo_wr_valid;
    logic        fifo_wr_credit;
    logic [7:0]  snoop_data;
    logic        snoop_valid;
    logic        snoop_match;
    logic        drop_pulse;
    logic [1:0]  drop_id;
    logic [15:0] drop_count;
    logic        err_credit_ovf;

    logic        force_match;
    int          cmps = 0;
    int          fails = 0;

    typedef struct {
        int         t;
        logic [7:0] d;
        int         id;
        bit         dup;
    } item_t;

    item_t       sb[$];
    logic [7:0]  fifo_q[$];
    int          gq[$];
    int          cyc = 0;
    int          m_cred = 10;
    int          m_rr = 3;
    int          m_drops = 0;
    int          m_ovf = 0;
    int          pushes_seen = 0;

    ah_snoop_fifo_wr_arb #(
        .NUM_REQ    (4),
        .DATA_W     (8),
        .FIFO_DEPTH (10),
        .DEDUP_EN   (1)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_wr_data   (fifo_wr_data),
        .fifo_wr_valid  (fifo_wr_valid),
        .fifo_wr_credit (fifo_wr_credit),
        .snoop_data     (snoop_data),
        .snoop_valid    (snoop_valid),
        .snoop_match    (snoop_match),
        .drop_pulse     (drop_pulse),
        .drop_id        (drop_id),
        .drop_count     (drop_count),
        .err_credit_ovf (err_credit_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input longint a, input longint e);
        cmps++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", n, a, e, $time);
        end
    endtask

    function automatic bit in_fifo(input logic [7:0] d);
        foreach (fifo_q[i]) if (fifo_q[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (last + k) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // FIFO side: combinational match answer from the bench's FIFO contents
    always begin
        @(posedge clk);
        #2;
        snoop_match = snoop_valid && (force_match || in_fifo(snoop_data));
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        bit pw;
        int g;
        logic [3:0] exp_rdy;
        cyc++;
        pw = 1'b0;
        if (!rstn) begin
            sb.delete();
            fifo_q.delete();
            m_cred  = 10;
            m_rr    = 3;
            m_drops = 0;
            m_ovf   = 0;
        end else begin
            chk("credit_cnt", dut.credit_cnt, m_cred);
            chk("drop_count", drop_count, m_drops);
            chk("err_credit_ovf", err_credit_ovf, m_ovf);
            exp_rdy = '0;
            g = rr_pick(req_valid, m_rr);
            if (sb.size() == 0 && m_cred != 0 && g >= 0) begin
                exp_rdy[g] = 1'b1;
                sb.push_back('{t: cyc, d: req_data[g*8 +: 8], id: g, dup: 1'b0});
                m_rr = g;
            end
            chk("req_ready", req_ready, exp_rdy);
            for (int i = 0; i < 4; i++) if (req_ready[i]) gq.push_back(i);
            if (snoop_valid) begin
                if (sb.size() == 0) chk("spurious_snoop", snoop_valid, 0);
                else begin
                    chk("snoop_time", cyc - sb[0].t, 1);
                    chk("snoop_data", snoop_data, sb[0].d);
                    sb[0].dup = force_match || in_fifo(sb[0].d);
                end
            end else begin
                chk("snoop_data_idle", snoop_data, 0);
                if (sb.size() > 0 && sb[0].t + 1 == cyc)
                    chk("missing_snoop", snoop_valid, 1);
            end
            if (fifo_wr_valid) pushes_seen++;
            if (fifo_wr_valid || drop_pulse ||
                (sb.size() > 0 && sb[0].t + 2 == cyc)) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", fifo_wr_valid | drop_pulse, 0);
                end else begin
                    chk("out_time", cyc - sb[0].t, 2);
                    chk("fifo_wr_valid", fifo_wr_valid, !sb[0].dup);
                    chk("drop_pulse", drop_pulse, sb[0].dup);
                    if (sb[0].dup) begin
                        chk("drop_id", drop_id, sb[0].id);
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        chk("fifo_wr_data", fifo_wr_data, sb[0].d);
                        fifo_q.push_back(sb[0].d);
                        pw = 1'b1;
                    end
                    void'(sb.pop_front());
                end
            end else begin
                chk("wr_data_idle", fifo_wr_data, 0);
                chk("drop_id_idle", drop_id, 0);
            end
            if (fifo_wr_credit && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (pw && !fifo_wr_credit) m_cred--;
            else if (!pw && fifo_wr_credit) begin
                if (m_cred == 10) m_ovf = 1;
                else m_cred++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
    endtask

    // returns at posedge+1 of the cycle after acceptance
    task automatic send(input int id, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        req_valid[id] = 1'b1;
        req_data[id*8 +: 8] = d;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = req_valid[id] && req_ready[id];
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        if (!ok) chk("send_timeout", ok, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] tk;
        int p0;
        rstn = 1'b0;
        req_valid = '0;
        req_data = '0;
        fifo_wr_credit = 1'b0;
        force_match = 1'b0;
        snoop_match = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_valid", fifo_wr_valid, 0);
        chk("rst_snoop_valid", snoop_valid, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_drop_id", drop_id, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_ovf", err_credit_ovf, 0);
        chk("rst_credit", dut.credit_cnt, 10);
        rstn = 1'b1;

        send(0, 8'h3C);
        chk("s1_snoop_valid", snoop_valid, 1);
        chk("s1_snoop_data", snoop_data, 8'h3C);
        idle(1);
        chk("s1_wr_valid", fifo_wr_valid, 1);
        chk("s1_wr_data", fifo_wr_data, 8'h3C);
        idle(1);
        chk("s1_credit", dut.credit_cnt, 9);

        do_reset();
        gq.delete();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(8'hA0 + i);
        req_valid = 4'hF;
        idle(13);
        req_valid = '0;
        idle(3);
        chk("rr_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++)
            chk("rr_order", gq[i], i % 4);

        do_reset();
        force_match = 1'b1;
        send(1, 8'h55);
        idle(1);
        force_match = 1'b0;
        chk("dr_pulse", drop_pulse, 1);
        chk("dr_id", drop_id, 1);
        chk("dr_wr_valid", fifo_wr_valid, 0);
        idle(1);
        chk("dr_count", drop_count, 1);
        chk("dr_credit", dut.credit_cnt, 10);

        do_reset();
        for (int i = 0; i < 10; i++) send(i % 4, 8'(8'h10 + i));
        idle(2);
        req_valid[2] = 1'b1;
        req_data[23:16] = 8'h77;
        idle(4);
        chk("ex_credit", dut.credit_cnt, 0);
        chk("ex_no_grant", req_ready, 0);
        fifo_wr_credit = 1'b1;
        idle(1);
        fifo_wr_credit = 1'b0;
        chk("ex_resume", req_ready, 4'b0100);
        send(2, 8'h77);
        idle(2);

        do_reset();
        for (int i = 0; i < 5; i++) send(i % 4, 8'(8'h20 + i));
        send(0, 8'h99);
        chk("cr_before", dut.credit_cnt, 5);
        idle(1);
        fifo_wr_credit = 1'b1;
        idle(1);
        fifo_wr_credit = 1'b0;
        chk("cr_same", dut.credit_cnt, 5);
        fifo_wr_credit = 1'b1;
        idle(5);
        chk("cr_full", dut.credit_cnt, 10);
        idle(1);
        fifo_wr_credit = 1'b0;
        chk("cr_ovf", err_credit_ovf, 1);
        chk("cr_hold", dut.credit_cnt, 10);

        do_reset();
        send(1, 8'hA5);
        chk("rs_in_snoop", snoop_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rs_snoop_valid", snoop_valid, 0);
        chk("rs_ready", req_ready, 0);
        chk("rs_credit", dut.credit_cnt, 10);
        p0 = pushes_seen;
        idle(2);
        rstn = 1'b1;
        idle(4);
        chk("rs_no_push", pushes_seen, p0);
        chk("rs_credit_after", dut.credit_cnt, 10);

        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            tk = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~tk;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            fifo_wr_credit = (fifo_q.size() > 0) && ($urandom_range(0, 2) == 0);
            force_match = ($urandom_range(0, 7) == 0);
        end
        req_valid = '0;
        fifo_wr_credit = 1'b0;
        force_match = 1'b0;
        idle(6);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", cmps, fails);
        $finish;
    end

endmodule
